// File: rtl/ex_pkg.sv
// ex_pkg: shared ALU op encodings and the execute-result entry type.
// EX_RESULT_FLAGS_EN adds the zero/neg/div0/illegal flag fields to each entry.
package ex_pkg;

    localparam int EX_N    = 32;
    localparam int EX_RD_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_MUL = 4'b0010,
        ALU_DIV = 4'b0011,
        ALU_AND = 4'b0100,
        ALU_OR  = 4'b0101,
        ALU_NOT = 4'b0110,
        ALU_SLL = 4'b0111,
        ALU_SRL = 4'b1000
    } alu_op_t;

    localparam logic [3:0] ALU_OP_LAST = 4'b1000;

    typedef struct packed {
        logic [EX_N-1:0]    z;
        logic [EX_RD_W-1:0] rd;
`ifdef EX_RESULT_FLAGS_EN
        logic               zero;
        logic               neg;
        logic               div0;
        logic               illegal;
`endif
    } ex_entry_t;

endpackage

// File: rtl/skid_fifo2.sv
// skid_fifo2: two-entry valid/ready FIFO of ex_entry_t with synchronous flush.
module skid_fifo2
    import ex_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    input  logic      in_valid,
    output logic      in_ready,
    input  ex_entry_t in_data,
    output logic      out_valid,
    input  logic      out_ready,
    output ex_entry_t out_data
);

    logic [1:0] count_q, count_d;
    ex_entry_t  head_q, head_d, tail_q, tail_d;
    logic       push, pop;

    assign in_ready  = (count_q != 2'd2) && !flush;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;

    // Retire first, then enqueue, so a simultaneous push at count 1 lands in the head slot.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            if (pop) begin
                head_d  = (count_q == 2'd2) ? tail_q : head_q;
                count_d = count_q - 2'd1;
            end
            if (push) begin
                if (count_d == 2'd0) head_d = in_data;
                else tail_d = in_data;
                count_d = count_d + 2'd1;
            end
        end
    end

    // State registers; head is left untouched when draining to empty so outputs hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/ex_result_stage.sv
// ex_result_stage: registers ALU results with status flags in a 2-deep skid buffer.
// Define EX_RESULT_FLAGS_EN to generate and store flags; otherwise flag outputs are 0.
module ex_result_stage
    import ex_pkg::*;
#(
    parameter int N    = EX_N,
    parameter int RD_W = EX_RD_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_z,
    input  logic [3:0]      in_op,
    input  logic [N-1:0]    in_b,
    input  logic [RD_W-1:0] in_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_z,
    output logic [RD_W-1:0] out_rd,
    output logic            out_zero,
    output logic            out_neg,
    output logic            out_div0,
    output logic            out_illegal
);

    ex_entry_t in_entry, head;

    assign in_entry.z  = in_z;
    assign in_entry.rd = in_rd;
    assign out_z       = head.z;
    assign out_rd      = head.rd;

`ifdef EX_RESULT_FLAGS_EN
    assign in_entry.zero    = (in_z == '0);
    assign in_entry.neg     = in_z[N-1];
    assign in_entry.div0    = (in_op == ALU_DIV) && (in_b == '0);
    assign in_entry.illegal = (in_op > ALU_OP_LAST);
    assign out_zero    = head.zero;
    assign out_neg     = head.neg;
    assign out_div0    = head.div0;
    assign out_illegal = head.illegal;
`else
    logic unused_flag_inputs;
    assign unused_flag_inputs = ^{in_op, in_b};
    assign out_zero    = 1'b0;
    assign out_neg     = 1'b0;
    assign out_div0    = 1'b0;
    assign out_illegal = 1'b0;
`endif

    skid_fifo2 u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

endmodule

// File: doc/ex_result_stage.md
# ex_result_stage

Execute-stage result register that sits directly downstream of the `alu`. It captures the ALU result `Z` together with the op select `S`, operand `B` and the destination register tag. It derives status flags and holds up to two results in a skid buffer with a valid/ready handshake. The memory/writeback stage drains the buffer, so it can stall without losing results already computed by the combinational ALU.

## Interface
- `N`, 32, data width (matches ALU `n`)
- `RD_W`, 5, destination register tag width
- `clk`  input  1  rising-edge clock
- `rst`  input  1  asynchronous, active-high reset
- `in_valid`  input  1  ALU result present this cycle
- `in_ready`  output  1  stage can accept a result this cycle
- `in_z`  input  N  ALU result `Z`
- `in_op`  input  4  ALU select `S` that produced `in_z`
- `in_b`  input  N  ALU operand `B` (used for divide-by-zero detection)
- `in_rd`  input  RD_W  destination register tag
- `flush`  input  1  synchronous discard of all held entries
- `out_valid`  output  1  head entry valid
- `out_ready`  input  1  downstream takes head entry
- `out_z`  output  N  head result
- `out_rd`  output  RD_W  head destination tag
- `out_zero`  output  1  head result == 0
- `out_neg`  output  1  head result bit N-1
- `out_div0`  output  1  head op was divide (4'b0011) with B == 0
- `out_illegal`  output  1  head op outside 4'b0000..4'b1000

## Operation
- Storage: 2-entry FIFO. Each entry holds `{z, rd, zero, neg, div0, illegal}`. Flags are computed at enqueue from `in_*` and stored. They are never recomputed at the output.
- Accept: `in_valid && in_ready`. Retire: `out_valid && out_ready`.
- `in_ready = (count < 2) && !flush`. It depends combinationally on `count` and `flush` only, never on `out_ready`.
- `out_valid = (count != 0)`. `out_*` always present the head entry. When `count == 0`, the contents are don't-care but are held at their last value.
- count 0: accept → 1.
- count 1: accept only → 2. Retire only → 0. Accept and retire together → 1, with the new entry becoming head.
- count 2: retire only → 1. No accept is possible.
- Order is strict FIFO; entries are never reordered or merged.
- Divide-by-zero result: `in_z` passes through unchanged; only `div0` is set.
- `illegal` is set for `in_op >= 4'b1001`. The entry is still queued and delivered.
- Flush has priority over both accept and retire:
  - `count` becomes 0 next cycle.
  - Input presented that cycle is not accepted.
  - Downstream must ignore `out_valid` during a flush cycle.
- Reset (async, any time, including mid-transfer):
  - `count = 0`, so `out_valid = 0` and `in_ready = 1` after release.
  - All entry storage and every `out_*` data and flag output = 0.

## Timing
- Latency: a result accepted at edge k is visible on `out_*` with `out_valid = 1` after edge k, i.e. one cycle.
- Throughput: 1 result/cycle sustained while `out_ready = 1`.
- Back-pressure: after two accepts with `out_ready = 0`, `in_ready` drops to 0 in the following cycle. No result is lost or duplicated.
- Bubble-free restart: when full and `out_ready` rises, `in_ready` = 1 in the cycle after the first retire.
- All outputs are register-driven, except `in_ready`, which is combinational on the `flush` term.

## Configuration
- Macro `EX_RESULT_FLAGS_EN`.
- Defined: `zero`, `neg`, `div0` and `illegal` are computed, stored and driven as specified above.
- Undefined: flag storage is removed, and `out_zero`, `out_neg`, `out_div0` and `out_illegal` are tied to 0. Ports still exist, and data/handshake behaviour is identical.

## Structure
- Package `ex_pkg` holds:
  - `alu_op_t` enum of the nine ALU encodings: ADD 0000, SUB 0001, MUL 0010, DIV 0011, AND 0100, OR 0101, NOT 0110, SLL 0111, SRL 1000.
  - `ALU_OP_LAST` = 4'b1000.
  - Packed struct `ex_entry_t` (parameterised widths via the package defaults N = 32, RD_W = 5).
- One sub-module, `skid_fifo2`: a generic 2-entry valid/ready FIFO of `ex_entry_t`, with `flush`. `ex_result_stage` adds flag generation and the macro.

## Test plan
- Reset mid-stream: load 2 entries, assert `rst` between edges → `out_valid = 0`, `in_ready = 1`, and `out_z = 0` immediately, before the next clock.
- Single pass: `in_z = 32'h0000_0005`, `in_op = ADD`, `in_rd = 3`, `out_ready = 1` → next cycle `out_z = 5`, `out_rd = 3`, `zero = 0`, `neg = 0`, then `out_valid = 0`.
- Back-pressure: accept 0xA, 0xB with `out_ready = 0` → `in_ready = 0`. Raise `out_ready` → 0xA then 0xB in order, with no duplicate.
- Simultaneous at count 1: head 0x1, accept 0x2 and retire in the same cycle → count stays 1, head = 0x2.
- Flags: DIV with `in_b = 0`, `in_z = 0xFFFF_FFFF` → `div0 = 1`, `neg = 1`. `in_op = 4'b1100` → `illegal = 1`. SUB with result 0 → `zero = 1`. With the macro undefined → all flags 0.
- Flush with count 2 and `in_valid = 1` → next cycle `out_valid = 0` and the input is dropped; a following accept of 0x7 emerges alone.
